// File: rtl/jk_updown_counter_pkg.sv
// Shared definitions for the JK-based modulo-N up/down counter:
// JK input codes, default geometry and the excitation encoder helper.
package jk_updown_counter_pkg;

  // JK input codes as seen by one cell, {j, k}
  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TOG  = 2'b11
  } jk_code_e;

  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_MODULUS = 10;

  // Inverse of the JK characteristic equation for one bit: given the present
  // and the desired next value, return {j, k}. Only HOLD, SET and CLR can come
  // out of this mapping; the toggle code is never produced.
  function automatic logic [1:0] jk_excite(input logic cur, input logic nxt);
    logic j_s;
    logic k_s;
    j_s = nxt & ~cur;
    k_s = ~nxt & cur;
    return {j_s, k_s};
  endfunction

endpackage

// File: rtl/jk_updown_counter_cell.sv
// One behavioural JK flip-flop with asynchronous active-low clear and preset.
// Clear dominates preset when both are asserted.
module jk_cell
  import jk_updown_counter_pkg::*;
(
  input  logic clk,
  input  logic clrn,
  input  logic prn,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qn
);

  logic q_r;

  // Cell state: async clear/preset, otherwise apply the JK code on the rising edge
  always_ff @(posedge clk or negedge clrn or negedge prn) begin
    if (!clrn) begin
      q_r <= 1'b0;
    end else if (!prn) begin
      q_r <= 1'b1;
    end else begin
      case (jk_code_e'({j, k}))
        JK_HOLD: q_r <= q_r;
        JK_CLR:  q_r <= 1'b0;
        JK_SET:  q_r <= 1'b1;
        JK_TOG:  q_r <= ~q_r;
        default: q_r <= q_r;
      endcase
    end
  end

  assign q  = q_r;
  assign qn = ~q_r;

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-MODULUS synchronous up/down counter. The state lives in WIDTH JK
// cells; the next state is chosen here and turned back into J/K inputs by the
// excitation encoder. tc is combinational so a cascaded stage can count on the
// same edge as this stage wraps.
module jk_updown_counter
  import jk_updown_counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = DEFAULT_MODULUS
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc
);

  // Reject an unusable modulus while elaborating
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("jk_updown_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
  end

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] qn_s;
  logic [WIDTH-1:0] next_s;
  logic [WIDTH-1:0] j_s;
  logic [WIDTH-1:0] k_s;

  // Next-state selection: load (with clamp) > count > hold; out-of-range
  // states fall back into range on the next counting edge
  always_comb begin
    next_s = q_s;
    if (load) begin
      if ({1'b0, d} < MOD_EXT) begin
        next_s = d;
      end else begin
        next_s = MAX_VAL;
      end
    end else if (en) begin
      if (up) begin
        if (q_s >= MAX_VAL) begin
          next_s = ZERO_VAL;
        end else begin
          next_s = q_s + ONE_VAL;
        end
      end else begin
        if ((q_s == ZERO_VAL) || (q_s > MAX_VAL)) begin
          next_s = MAX_VAL;
        end else begin
          next_s = q_s - ONE_VAL;
        end
      end
    end else begin
      next_s = q_s;
    end
  end

  // Excitation encoder and one JK cell per state bit; preset is unused
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign {j_s[i], k_s[i]} = jk_excite(q_s[i], next_s[i]);

    jk_cell u_cell (
      .clk  (clk),
      .clrn (clrn),
      .prn  (1'b1),
      .j    (j_s[i]),
      .k    (k_s[i]),
      .q    (q_s[i]),
      .qn   (qn_s[i])
    );
  end

  assign q  = q_s;
  assign qn = qn_s;

  // Terminal count: boundary state in the current counting direction, never during a load
  assign tc = en & ~load & ((up & (q_s == MAX_VAL)) | (~up & (q_s == ZERO_VAL)));

endmodule

// File: tb/tb_jk_updown_counter.sv
// Self-checking bench for jk_updown_counter: directed boundary steps followed by
// random stimulus, all compared against an integer reference model.
module tb_jk_updown_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         clrn;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic [W-1:0] qn;
  logic         tc;

  int vectors     = 0;
  int miscompares = 0;
  int model       = 0;

  jk_updown_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk  (clk),
    .clrn (clrn),
    .en   (en),
    .up   (up),
    .load (load),
    .d    (d),
    .q    (q),
    .qn   (qn),
    .tc   (tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Counter behaviour from the rules: clamp on load, modular step when enabled
  function automatic int ref_next(input int cur);
    int dv;
    dv = int'(d);
    if (load) return (dv < M) ? dv : M - 1;
    if (en)   return up ? (cur + 1) % M : (cur + M - 1) % M;
    return cur;
  endfunction

  function automatic logic ref_tc(input int cur);
    return en && !load && ((up && cur == M - 1) || (!up && cur == 0));
  endfunction

  // One clock step: check combinational outputs before the edge, then the new state
  task automatic step(input string tag);
    int nxt;
    #1;
    check({tag, "/tc"}, tc, ref_tc(model));
    check({tag, "/jk_toggle"}, dut.j_s & dut.k_s, 0);
    nxt = ref_next(model);
    if (nxt == model) check({tag, "/hold_jk"}, {dut.j_s, dut.k_s}, 0);
    @(posedge clk);
    #1;
    model = nxt;
    check({tag, "/q"}, q, model);
    check({tag, "/qn"}, qn, (~model) & ((1 << W) - 1));
  endtask

  initial begin
    clrn = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; d = '0;
    model = 0;
    #3;
    check("reset/q", q, 0);
    check("reset/qn", qn, 15);
    #5 clrn = 1'b1;
    @(posedge clk); #1;

    // Count up to 7, then clear asynchronously mid-count
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 7; i++) step("to7");
    check("at7/q", q, 7);
    #2 clrn = 1'b0;
    #1;
    check("midreset/q", q, 0);
    check("midreset/qn", qn, 15);
    check("midreset/tc_up", tc, 0);
    up = 1'b0;
    #1;
    check("midreset/tc_down", tc, 1);
    up = 1'b1;
    model = 0;
    #1 clrn = 1'b1;
    step("release");
    check("release/q1", q, 1);

    // Up wrap from 0 over 12 edges
    load = 1'b1; d = 4'd0; step("load0");
    load = 1'b0;
    for (int i = 0; i < 12; i++) step("upwrap");
    check("upwrap/end", q, 2);

    // Down wrap from 0
    load = 1'b1; d = 4'd0; step("load0b");
    load = 1'b0; up = 1'b0;
    for (int i = 0; i < 3; i++) step("downwrap");
    check("downwrap/end", q, 7);

    // Load priority over enable, then clamp
    load = 1'b1; en = 1'b1; up = 1'b1; d = 4'd5; step("loadprio");
    check("loadprio/q5", q, 5);
    d = 4'd12; step("clamp");
    check("clamp/q9", q, 9);

    // Hold at 6
    d = 4'd6; step("load6");
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) step("hold");
    check("hold/q6", q, 6);

    // Direction flip at the top boundary
    load = 1'b1; d = 4'd9; step("load9");
    load = 1'b0; en = 1'b1; up = 1'b0; step("flip");
    check("flip/q8", q, 8);

    // Random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      load = ($urandom_range(0, 7) == 0);
      en   = ($urandom_range(0, 3) != 0);
      up   = $urandom_range(0, 1) == 1;
      d    = W'($urandom_range(0, 15));
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
